// File: rtl/mup_pkg.sv
// mup_pkg: shared types and constants for the mup fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, REQ, WAIT)
//   fetch_entry_t : one prefetch FIFO entry, {pc, instr}
//   OPC_W         : opcode field width, taken from the top of the instruction
//   RST_VEC_DEF / INT_VEC_DEF : default reset and interrupt vectors
// The entry struct is sized by PC_W / INSTR_W, so mup_fetch must be built
// with AW == PC_W and DW == INSTR_W.
package mup_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int OPC_W   = 4;

  localparam logic [PC_W-1:0] RST_VEC_DEF = 8'h00;
  localparam logic [PC_W-1:0] INT_VEC_DEF = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/mup_fetch_fifo.sv
// mup_fetch_fifo: synchronous prefetch FIFO of fetch_entry_t with a
// registered head.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wdata     : write one entry (caller guarantees not full)
//   pop             : remove the head (ignored when empty)
//   flush           : drop all entries; wins over push and pop
//   count           : number of stored entries
//   head_valid/head : registered head entry, updated on the same edge
//                     that changes the FIFO contents
module mup_fetch_fifo
  import mup_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_next;
  fetch_entry_t  head_next;

  assign do_pop = pop & head_valid;

  // The next head is read from the array at the advanced read pointer,
  // except when the FIFO drains to nothing this cycle: then the entry being
  // pushed is not yet in the array and is forwarded straight to the head.
  always_comb begin
    rd_next    = rd_ptr + PW'(do_pop);
    count_next = count + CW'(push) - CW'(do_pop);
    head_next  = mem[rd_next];
    if ((count - CW'(do_pop)) == '0) head_next = wdata;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head       <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (count_next != '0) head <= head_next;
    end
  end

endmodule

// File: rtl/mup_fetch.sv
// mup_fetch: instruction-fetch stage feeding the mup_opr core.
// Issues single-outstanding memory reads from fetch_pc, buffers {pc, instr}
// in a prefetch FIFO and offers the head to the core. Handles branch
// redirects and interrupt entry (redirect to INT_VEC with ack pulse).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   en                               : fetch enable (in-flight read always completes)
//   int_req / int_ack / int_ret_pc   : interrupt request, entry pulse, return PC
//   mem_req/mem_addr/mem_gnt         : read request channel
//   mem_rvalid/mem_rdata             : read response channel
//   redir_valid/redir_pc             : redirect from the core
//   ir_valid/ir_ready/ir_out/pc_out/dcop_out : instruction port to the core
//   fetch_state                      : current FSM state (debug)
// Optional build macro MUP_FETCH_PERF_EN adds perf_fetch_cnt (accepted
// pushes) and perf_stall_cnt (cycles with en=1 and no valid head), both
// saturating 16-bit counters.
//
// Instruction port handshake: ir_valid/ir_out/pc_out/dcop_out come from
// registers and are held stable until the core takes them; an entry is
// transferred on every rising edge where ir_valid and ir_ready are both 1.
// ir_ready may depend on ir_valid, never the reverse. A flush may withdraw
// ir_valid without a transfer.
module mup_fetch
  import mup_pkg::*;
#(
  parameter int              AW      = PC_W,
  parameter int              DW      = INSTR_W,
  parameter int              DEPTH   = 4,
  parameter logic [AW-1:0]   RST_VEC = RST_VEC_DEF,
  parameter logic [AW-1:0]   INT_VEC = INT_VEC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              int_req,
  output logic              int_ack,
  output logic [AW-1:0]     int_ret_pc,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              redir_valid,
  input  logic [AW-1:0]     redir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DW-1:0]     ir_out,
  output logic [AW-1:0]     pc_out,
  output logic [OPC_W-1:0]  dcop_out,
  output fetch_state_e      fetch_state
`ifdef MUP_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int CA_W = CW + 1;

  fetch_state_e  state;
  logic [AW-1:0] fetch_pc;
  logic [AW-1:0] req_pc;
  logic          discard;
  logic          int_active;

  logic [CW-1:0] count;
  logic          head_valid;
  fetch_entry_t  head;
  fetch_entry_t  wdata;

  logic          pop;
  logic          push;
  logic          int_take;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [CA_W-1:0] count_after;
  logic          room;

  assign pop      = head_valid & ir_ready;
  assign int_take = int_req & en & ~int_active;
  assign flush    = int_take | redir_valid;
  // Interrupt entry wins over a redirect in the same cycle.
  assign flush_pc = int_take ? INT_VEC : redir_pc;
  // A response arriving in a flush cycle belongs to the old stream.
  assign push     = (state == WAIT) & mem_rvalid & ~discard & ~flush;

  assign wdata.pc    = req_pc;
  assign wdata.instr = mem_rdata;

  // Occupancy as it will be after this edge. New reads are only issued while
  // this leaves a free slot, which is what keeps every push from overflowing.
  always_comb begin
    count_after = {1'b0, count} + CA_W'(push) - CA_W'(pop);
    if (flush) count_after = '0;
    room = en & (count_after < CA_W'(DEPTH));
  end

  mup_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .wdata      (wdata),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      fetch_pc <= RST_VEC;
      req_pc   <= '0;
      discard  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) fetch_pc <= flush_pc;
          if (room) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            // A flush alongside the grant marks this read stale.
            req_pc   <= fetch_pc;
            fetch_pc <= flush ? flush_pc : fetch_pc + AW'(1);
            discard  <= flush;
            state    <= WAIT;
            mem_req  <= 1'b0;
          end else if (flush) begin
            fetch_pc <= flush_pc;
          end
        end
        WAIT: begin
          if (flush) begin
            fetch_pc <= flush_pc;
            discard  <= 1'b1;
          end
          if (mem_rvalid) begin
            discard <= 1'b0;
            if (room) begin
              state   <= REQ;
              mem_req <= 1'b1;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // int_active blocks re-entry until int_req has been seen low once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_active <= 1'b0;
      int_ack    <= 1'b0;
      int_ret_pc <= '0;
    end else begin
      int_ack <= int_take;
      if (int_take) begin
        int_active <= 1'b1;
        int_ret_pc <= redir_valid ? redir_pc : (head_valid ? head.pc : fetch_pc);
      end else if (int_active && !int_req) begin
        int_active <= 1'b0;
      end
    end
  end

`ifdef MUP_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != 16'hFFFF) perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (!head_valid && en && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

  assign mem_addr    = fetch_pc;
  assign ir_valid    = head_valid;
  assign ir_out      = head.instr;
  assign pc_out      = head.pc;
  assign dcop_out    = opcode_of(head.instr);
  assign fetch_state = state;

endmodule

// File: tb/tb_mup_fetch.sv
// tb_mup_fetch: self-checking bench for mup_fetch.
// A behavioural memory answers reads; a reference model tracks the expected
// fetch address, the queue of buffered {pc, instr} entries and the interrupt
// state from the architectural rules, and every cycle is compared against it.
`timescale 1ns/1ps
module tb_mup_fetch;
  import mup_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RST_V = 8'h00;
  localparam logic [AW-1:0] INT_V = 8'hF0;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          en = 1'b0, int_req = 1'b0, int_ack;
  logic [AW-1:0] int_ret_pc;
  logic          mem_req, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          redir_valid = 1'b0;
  logic [AW-1:0] redir_pc = '0;
  logic          ir_valid, ir_ready = 1'b0;
  logic [DW-1:0] ir_out;
  logic [AW-1:0] pc_out;
  logic [3:0]    dcop_out;
  fetch_state_e  fetch_state;
`ifdef MUP_FETCH_PERF_EN
  logic [15:0]   perf_fetch_cnt, perf_stall_cnt;
`endif

  mup_fetch #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .int_req     (int_req),
    .int_ack     (int_ack),
    .int_ret_pc  (int_ret_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_out      (ir_out),
    .pc_out      (pc_out),
    .dcop_out    (dcop_out),
    .fetch_state (fetch_state)
`ifdef MUP_FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state
  logic [AW+DW-1:0] exp_q[$];     // buffered entries, {pc, instr}
  logic [AW-1:0]    m_fetch;      // address the next read must use
  logic             m_int_active;
  logic             exp_ack;
  logic [AW-1:0]    exp_ret;
  int               n_gnt, n_ack, n_pops;
  logic [AW-1:0]    last_pop_pc;
  logic             have_last_pop;
  bit               seen_wrap;
  int               m_push_cnt, m_stall_cnt;

  // Memory responder state
  logic          mp_pending = 1'b0;
  logic          mp_stale   = 1'b0;
  logic [AW-1:0] mp_addr;
  int            mp_delay;
  int            max_lat = 0;
  int            gnt_pct = 100;
  bit            hash_mode = 1'b0;

  function automatic logic [DW-1:0] mem_func(input logic [AW-1:0] a);
    if (hash_mode) return {a[3:0] ^ 4'h9, 4'hA, a};
    return 16'h1A00 + {8'h00, a};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the core-side inputs already set. Drives
  // memory, advances the model across the coming rising edge, and returns
  // at the next falling edge after checking the registered interrupt outputs.
  task automatic tick();
    logic             rv, rv_stale, do_pop, take, fl, keep, model_valid;
    logic [AW-1:0]    tgt;
    logic [AW+DW-1:0] e;

    model_valid = (exp_q.size() != 0);
    check_eq("ir_valid", ir_valid, model_valid);
    check_eq("mem_addr", mem_addr, m_fetch);

    // memory side
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = DW'($urandom);
    rv         = 1'b0;
    rv_stale   = 1'b0;
    if (mp_pending) begin
      if (mp_delay == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_func(mp_addr);
        rv         = 1'b1;
        rv_stale   = mp_stale;
        mp_pending = 1'b0;
      end else begin
        mp_delay--;
      end
    end else if (mem_req && ($urandom_range(0, 99) < gnt_pct)) begin
      mem_gnt    = 1'b1;
      mp_pending = 1'b1;
      mp_stale   = 1'b0;
      mp_addr    = mem_addr;
      mp_delay   = $urandom_range(0, max_lat);
      n_gnt++;
    end

    // model across the rising edge
    do_pop = ir_valid && ir_ready;
    take   = int_req && en && !m_int_active;
    fl     = take || redir_valid;
    tgt    = take ? INT_V : redir_pc;

    if (!model_valid && en) m_stall_cnt++;

    if (take) begin
      if (redir_valid)      exp_ret = redir_pc;
      else if (model_valid) exp_ret = exp_q[0][AW+DW-1:DW];
      else                  exp_ret = m_fetch;
    end
    exp_ack = take;

    if (do_pop) begin
      check_eq("pop_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("pc_out", pc_out, e[AW+DW-1:DW]);
        check_eq("ir_out", ir_out, e[DW-1:0]);
        check_eq("dcop_out", dcop_out, e[DW-1:DW-4]);
        if (have_last_pop && last_pop_pc == 8'hFF && e[AW+DW-1:DW] == 8'h00) seen_wrap = 1'b1;
        last_pop_pc   = e[AW+DW-1:DW];
        have_last_pop = 1'b1;
        n_pops++;
      end
    end

    if (fl) begin
      exp_q.delete();
      if (mp_pending) mp_stale = 1'b1;
      m_fetch = tgt;
    end else if (mem_gnt) begin
      m_fetch = m_fetch + 8'd1;
    end

    keep = rv && !rv_stale && !fl;
    if (keep) begin
      exp_q.push_back({mp_addr, mem_rdata});
      m_push_cnt++;
      check_eq("fifo_bound", exp_q.size() <= DEPTH, 1'b1);
    end

    if (take)                           m_int_active = 1'b1;
    else if (m_int_active && !int_req)  m_int_active = 1'b0;

    @(negedge clk);
    check_eq("int_ack", int_ack, exp_ack);
    if (exp_ack) check_eq("int_ret_pc", int_ret_pc, exp_ret);
    if (int_ack) n_ack++;
  endtask

  // Asserts reset asynchronously a little after a falling edge, checks the
  // cleared outputs without any clock edge, releases at the next falling edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    en = 1'b0; int_req = 1'b0; redir_valid = 1'b0; redir_pc = '0; ir_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    check_eq("rst_ir_valid", ir_valid, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_addr", mem_addr, RST_V);
    check_eq("rst_pc_out", pc_out, 8'h00);
    check_eq("rst_ir_out", ir_out, 16'h0000);
    check_eq("rst_dcop", dcop_out, 4'h0);
    check_eq("rst_int_ack", int_ack, 1'b0);
    check_eq("rst_int_ret", int_ret_pc, 8'h00);
    check_eq("rst_state", fetch_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_fetch = RST_V; m_int_active = 1'b0; exp_ack = 1'b0;
    have_last_pop = 1'b0; m_push_cnt = 0; m_stall_cnt = 0;
    if (mp_pending) mp_stale = 1'b1;  // a response still in flight is now orphaned
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k;
    k = 0;
    while (!ir_valid && k < budget) begin tick(); k++; end
    if (!ir_valid) check_eq({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  task automatic wait_in_wait(input string tag, input int budget);
    int k;
    k = 0;
    while (!(mp_pending && mp_delay > 0) && k < budget) begin tick(); k++; end
    if (!(mp_pending && mp_delay > 0)) check_eq({tag, "_timeout"}, 1'b0, 1'b1);
  endtask

  // ---------------- tests ----------------
  initial begin
    n_gnt = 0; n_ack = 0; n_pops = 0; seen_wrap = 1'b0;
    @(negedge clk);
    do_reset();

    // 1: streaming with 1-cycle memory, ready always high
    en = 1'b1; ir_ready = 1'b1; max_lat = 0; gnt_pct = 100;
    n_pops = 0;
    repeat (40) tick();
    check_eq("t1_progress", n_pops >= 15, 1'b1);

    // 2: core stalls; fetch must stop after DEPTH buffered entries
    do_reset();
    en = 1'b1; ir_ready = 1'b0; n_gnt = 0;
    repeat (20) tick();
    check_eq("t2_grants", n_gnt, DEPTH);
    check_eq("t2_mem_req_low", mem_req, 1'b0);
    check_eq("t2_head_pc", pc_out, 8'h00);
    ir_ready = 1'b1; n_pops = 0;
    repeat (20) tick();
    check_eq("t2_drain", n_pops >= 5, 1'b1);

    // 3: redirect while a read is outstanding
    max_lat = 2;
    wait_in_wait("t3", 60);
    check_eq("t3_in_wait", fetch_state, WAIT);
    redir_valid = 1'b1; redir_pc = 8'h40;
    tick();
    redir_valid = 1'b0;
    wait_valid("t3", 60);
    check_eq("t3_redir_pc", pc_out, 8'h40);

    // 4: interrupt with head pc 05, request held high
    ir_ready = 1'b0;
    redir_valid = 1'b1; redir_pc = 8'h05;
    tick();
    redir_valid = 1'b0;
    wait_valid("t4", 60);
    check_eq("t4_head", pc_out, 8'h05);
    int_req = 1'b1; n_ack = 0;
    tick();
    check_eq("t4_ack", int_ack, 1'b1);
    check_eq("t4_ret_pc", int_ret_pc, 8'h05);
    ir_ready = 1'b1;
    wait_valid("t4", 60);
    check_eq("t4_vec_pc", pc_out, 8'hF0);
    repeat (10) tick();
    check_eq("t4_single_ack", n_ack, 1);
    int_req = 1'b0;
    repeat (3) tick();

    // 5: interrupt and redirect together; interrupt wins
    ir_ready = 1'b0;
    int_req = 1'b1; redir_valid = 1'b1; redir_pc = 8'h22;
    tick();
    int_req = 1'b0; redir_valid = 1'b0;
    check_eq("t5_ack", int_ack, 1'b1);
    check_eq("t5_ret_pc", int_ret_pc, 8'h22);
    ir_ready = 1'b1;
    wait_valid("t5", 60);
    check_eq("t5_vec_pc", pc_out, 8'hF0);
    repeat (4) tick();

    // 6a: PC wrap 0xFF -> 0x00
    redir_valid = 1'b1; redir_pc = 8'hFC;
    tick();
    redir_valid = 1'b0;
    repeat (30) tick();
    check_eq("t6_wrap", seen_wrap, 1'b1);

    // 6b: reset in the middle of a read; the late response must be ignored
    max_lat = 3;
    wait_in_wait("t6", 60);
    do_reset();
    en = 1'b1; ir_ready = 1'b0;
    wait_valid("t6", 60);
    check_eq("t6_first_pc", pc_out, 8'h00);
    check_eq("t6_first_instr", ir_out, 16'h1A00);

    // random phase
    hash_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      en          = ($urandom_range(0, 99) < 90);
      ir_ready    = ($urandom_range(0, 99) < 70);
      redir_valid = ($urandom_range(0, 99) < 4);
      redir_pc    = AW'($urandom);
      if ($urandom_range(0, 99) < 5) int_req = ~int_req;
      max_lat     = $urandom_range(0, 3);
      gnt_pct     = 70;
      tick();
    end
    redir_valid = 1'b0; int_req = 1'b0;
    repeat (4) tick();

`ifdef MUP_FETCH_PERF_EN
    check_eq("perf_fetch", perf_fetch_cnt, m_push_cnt);
    check_eq("perf_stall", perf_stall_cnt, m_stall_cnt);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
